// File: rtl/serdes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serdes_pkg
// Description : Shared SERDES definitions: comma symbols, serializer state
//               encoding and default word width.
// Revision    : 1.0 - initial release
// ============================================================================
package serdes_pkg;

    // Default encoded word width (8b10b symbol)
    localparam int DEFAULT_NUM_BITS = 10;

    // K28.5 comma symbol, both running disparities
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    // Serializer line state
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } piso_state_e;

endpackage
`default_nettype wire

// File: rtl/piso_hold_buf.sv
`default_nettype none
// ============================================================================
// Module      : piso_hold_buf
// Description : One-entry valid/ready hold register feeding the serializer.
//               Ready depends only on registered state, never on valid.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_hold_buf #(
    parameter int NUM_BITS = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_BITS-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                pop,
    output logic [NUM_BITS-1:0] hold_data,
    output logic                hold_valid
);

    // Held low through reset so ready cannot assert until the first
    // clock edge after release.
    logic ready_en;
    logic accept;

    assign accept   = in_valid && in_ready;
    assign in_ready = ready_en && !hold_valid;

    // Hold register: fill on handshake, clear when the serializer loads it.
    // Fill and pop are mutually exclusive because ready requires an empty hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en   <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else begin
            ready_en <= 1'b1;
            if (pop) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= in_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in / serial-out transmitter. Shifts buffered words
//               MSB-first on each bit strobe and substitutes an idle comma
//               word at a word boundary when no data is buffered.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
    import serdes_pkg::*;
#(
    parameter int                  NUM_BITS  = DEFAULT_NUM_BITS,
    parameter logic [NUM_BITS-1:0] IDLE_WORD = NUM_BITS'(K28_5_RDN)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [NUM_BITS-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                sd_out,
    output logic                sd_active,
    output logic                word_start,
    output logic                underrun
);

    localparam int                CNT_W    = $clog2(NUM_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

    piso_state_e          state, state_next;
    logic [NUM_BITS-1:0]  shreg, shreg_next;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_next;
    logic                 underrun_q, underrun_next;
    logic                 pop;
    logic [NUM_BITS-1:0]  hold_data;
    logic                 hold_valid;

    piso_hold_buf #(
        .NUM_BITS (NUM_BITS)
    ) u_hold (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pop        (pop),
        .hold_data  (hold_data),
        .hold_valid (hold_valid)
    );

    // Next-state, shifter and counter decode; everything holds unless strobed.
    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        bit_cnt_next  = bit_cnt;
        underrun_next = 1'b0;
        pop           = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && hold_valid) begin
                    shreg_next   = hold_data;
                    bit_cnt_next = '0;
                    pop          = 1'b1;
                    state_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (enable) begin
                    if (bit_cnt == LAST_BIT) begin
                        // Word boundary: next word or comma fill, never a gap
                        bit_cnt_next = '0;
                        if (hold_valid) begin
                            shreg_next = hold_data;
                            pop        = 1'b1;
                        end else begin
                            shreg_next    = IDLE_WORD;
                            underrun_next = 1'b1;
                        end
                    end else begin
                        shreg_next   = {shreg[NUM_BITS-2:0], 1'b0};
                        bit_cnt_next = bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shift register, bit counter and one-cycle underrun flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            underrun_q <= 1'b0;
        end else begin
            shreg      <= shreg_next;
            bit_cnt    <= bit_cnt_next;
            underrun_q <= underrun_next;
        end
    end

    // The shift register is all-zero whenever the line is idle, so its MSB
    // can drive the line directly without extra gating.
    assign sd_out     = shreg[NUM_BITS-1];
    assign sd_active  = (state == ST_RUN);
    assign word_start = (state == ST_RUN) && (bit_cnt == '0);
    assign underrun   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Self-checking bench for piso_serializer: scoreboard of
//               accepted words feeding a bit-queue line model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int             NB   = 10;
    localparam logic [NB-1:0] IDLE = 10'b0011111010;

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic [NB-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          sd_out;
    logic          sd_active;
    logic          word_start;
    logic          underrun;

    piso_serializer #(
        .NUM_BITS  (NB),
        .IDLE_WORD (IDLE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sd_out     (sd_out),
        .sd_active  (sd_active),
        .word_start (word_start),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard of accepted words, stamped with the edge that accepted them
    typedef struct {
        logic [NB-1:0] data;
        int            cyc;
    } word_t;
    word_t wordq[$];

    // Expected line content, one entry per serial bit still to be shown
    typedef struct {
        logic b;
        logic first;
    } bit_t;
    bit_t bitq[$];

    int   edge_cnt  = 0;
    logic last_en   = 1'b0;
    logic ready_en  = 1'b0;
    logic acc_flag  = 1'b0;
    bit   running   = 1'b0;
    bit   exp_under = 1'b0;

    // Stimulus-side observer: records handshakes into the scoreboard
    initial begin
        word_t w;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                ready_en = 1'b0;
                last_en  = 1'b0;
                acc_flag = 1'b0;
                wordq.delete();
            end else begin
                edge_cnt++;
                last_en  = enable;
                acc_flag = in_valid && ready_en && (wordq.size() == 0);
                if (acc_flag) begin
                    w.data = in_data;
                    w.cyc  = edge_cnt;
                    wordq.push_back(w);
                end
                ready_en = 1'b1;
            end
        end
    end

    task automatic push_word(input logic [NB-1:0] w);
        bit_t e;
        for (int i = NB - 1; i >= 0; i--) begin
            e.b     = w[i];
            e.first = (i == NB - 1);
            bitq.push_back(e);
        end
    endtask

    // Monitor: advances the line model one bit per strobe and compares
    initial begin
        word_t w;
        bit    need;
        logic  e_out, e_ws, e_rdy;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                running   = 1'b0;
                exp_under = 1'b0;
                bitq.delete();
            end else begin
                exp_under = 1'b0;
                if (last_en) begin
                    need = !running;
                    if (running) begin
                        if (bitq.size() > 0) bitq.delete(0);
                        need = (bitq.size() == 0);
                    end
                    if (need) begin
                        if (wordq.size() > 0 && wordq[0].cyc < edge_cnt) begin
                            w = wordq.pop_front();
                            push_word(w.data);
                            running = 1'b1;
                        end else if (running) begin
                            push_word(IDLE);
                            exp_under = 1'b1;
                        end
                    end
                end
            end
            e_out = (running && bitq.size() > 0) ? bitq[0].b : 1'b0;
            e_ws  = (running && bitq.size() > 0) ? bitq[0].first : 1'b0;
            e_rdy = reset_n && ready_en && (wordq.size() == 0);
            check("in_ready",   in_ready,   e_rdy);
            check("sd_active",  sd_active,  running);
            check("sd_out",     sd_out,     e_out);
            check("word_start", word_start, e_ws);
            check("underrun",   underrun,   exp_under);
        end
    end

    // Enable pattern: 1 = every cycle, 4 = every 4th cycle, 0 = random
    int en_mode = 1;
    int phase   = 0;

    task automatic step();
        @(negedge clk);
        phase++;
        case (en_mode)
            1:       enable = 1'b1;
            4:       enable = ((phase % 4) == 0);
            default: enable = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic send(input logic [NB-1:0] w);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int n = 0; n < 200 && !done; n++) begin
            step();
            if (acc_flag) done = 1'b1;
        end
        in_valid = 1'b0;
        check("send_accept", done, 1'b1);
    endtask

    initial begin
        logic [NB-1:0] pat;
        logic [NB-1:0] rx;
        int            cnt;
        bit            cap;
        bit            got;

        // Reset with valid asserted: ready must stay low
        reset_n  = 1'b0;
        enable   = 1'b1;
        in_valid = 1'b1;
        in_data  = 10'h3AB;
        repeat (3) step();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_sd_out",   sd_out,   1'b0);
        #2;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        step();
        check("rel_in_ready", in_ready, 1'b1);

        // Single word, then comma fill with underrun at the boundary
        pat = 10'h2A5;
        send(pat);
        step();
        for (int i = 0; i < NB; i++) begin
            check("w2A5_bit",   sd_out,     pat[NB-1-i]);
            check("w2A5_start", word_start, (i == 0));
            step();
        end
        check("w2A5_underrun", underrun,   1'b1);
        check("w2A5_idle_ws",  word_start, 1'b1);
        check("w2A5_idle_b9",  sd_out,     IDLE[NB-1]);
        repeat (12) step();

        // Back-to-back words with valid held
        send(10'h3FF);
        send(10'h000);
        send(10'h155);
        repeat (35) step();

        // Reset in the middle of a word with a second word held
        send(10'h0F0);
        send(10'h30C);
        repeat (4) step();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_sd_out",    sd_out,    1'b0);
        check("midrst_sd_active", sd_active, 1'b0);
        check("midrst_in_ready",  in_ready,  1'b0);
        repeat (2) step();
        #2;
        reset_n = 1'b1;
        step();

        // Strobe every 4th cycle, loopback into a receiver shift register
        en_mode = 4;
        send(10'h2A5);
        cap = 1'b0;
        got = 1'b0;
        cnt = 0;
        rx  = '0;
        for (int n = 0; n < 300 && !got; n++) begin
            step();
            if (!cap && enable && word_start) cap = 1'b1;
            if (cap && enable) begin
                rx = {rx[NB-2:0], sd_out};
                cnt++;
                if (cnt == NB) got = 1'b1;
            end
        end
        check("loopback_done", got, 1'b1);
        check("loopback_data", rx,  10'h2A5);

        // Randomized traffic with random strobes; valid may sit while not ready
        en_mode = 0;
        for (int n = 0; n < 800; n++) begin
            step();
            in_valid = $urandom_range(0, 1);
            in_data  = NB'($urandom);
        end
        in_valid = 1'b0;
        en_mode  = 1;
        repeat (30) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
